pcie_lane_loopback: RTL and testbench

//  Parametrised cycle-based PCIe serial-lane loopback channel for simulation benches.

---
 rtl/pcie_loop_pkg.sv | 15 +
 rtl/pcie_lane_loopback_if.sv | 25 ++
 rtl/pcie_loop_delay_line.sv | 36 +++
 rtl/pcie_lane_loopback.sv | 146 ++++++++++++++
 tb/tb_pcie_lane_loopback.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_loop_pkg.sv
// Shared types and constants for the PCIe lane loopback channel.
package pcie_loop_pkg;

  // Link FSM encoding, also exported on the link_state port.
  typedef enum logic [1:0] {
    DOWN = 2'd0,
    FILL = 2'd1,
    UP   = 2'd2
  } link_state_t;

  // Level driven on the receive pairs whenever the link is not carrying data.
  localparam logic IDLE_P = 1'b0;
  localparam logic IDLE_N = 1'b0;

endpackage

// File: rtl/pcie_lane_loopback_if.sv
// Serial lane bundle between an endpoint (master) and the loopback channel (slave).
interface pcie_lane_loopback_if #(
  parameter int LANES = 4
);

  logic [LANES-1:0] pci_exp_txp;
  logic [LANES-1:0] pci_exp_txn;
  logic [LANES-1:0] pci_exp_rxp;
  logic [LANES-1:0] pci_exp_rxn;

  modport master (
    output pci_exp_txp,
    output pci_exp_txn,
    input  pci_exp_rxp,
    input  pci_exp_rxn
  );

  modport slave (
    input  pci_exp_txp,
    input  pci_exp_txn,
    output pci_exp_rxp,
    output pci_exp_rxn
  );

endinterface

// File: rtl/pcie_loop_delay_line.sv
// Variable-depth shift register. A delay of 0 passes din straight to the tap
// so the caller's output register alone provides the one-cycle path.
module pcie_loop_delay_line #(
  parameter int   WIDTH     = 4,
  parameter int   MAX_DELAY = 32,
  parameter logic IDLE      = 1'b0,
  localparam int  DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk_200,
  input  logic             flush,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [MAX_DELAY];

  // Shift one stage per clock, or wipe every stage back to the idle level.
  always_ff @(posedge clk_200) begin
    if (flush) begin
      for (int k = 0; k < MAX_DELAY; k++) stage[k] <= {WIDTH{IDLE}};
    end else begin
      stage[0] <= din;
      for (int k = 1; k < MAX_DELAY; k++) stage[k] <= stage[k-1];
    end
  end

  // Tap select: stage delay-1 holds the word sampled delay cycles ago.
  always_comb begin
    dout = din;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (delay == DW'(k + 1)) dout = stage[k];
    end
  end

endmodule

// File: rtl/pcie_lane_loopback.sv
// Cycle-based PCIe lane loopback: tx pairs return on rx pairs after a
// programmable delay, with link up/down control and lane reversal.
// Optional periodic bit-error injection is built when the macro
// PCIE_LOOP_ERR_INJECT_EN is defined; otherwise err_count reads 0.
module pcie_lane_loopback
  import pcie_loop_pkg::*;
#(
  parameter int  LANES         = 4,
  parameter int  MAX_DELAY     = 32,
  parameter int  DEFAULT_DELAY = 4,
  localparam int DW            = $clog2(MAX_DELAY + 1),
  localparam int EW            = $clog2(LANES) + 1
) (
  input  logic                 clk_200,
  input  logic                 sys_rst_n,
  input  logic                 link_en,
  input  logic                 lane_rev,
  input  logic [DW-1:0]        delay_cfg,
  input  logic                 delay_cfg_we,
  pcie_lane_loopback_if.slave  lanes,
  output logic                 link_up,
  output logic [1:0]           link_state,
  input  logic [15:0]          err_every,
  input  logic [EW-1:0]        err_lane,
  output logic [31:0]          err_count
);

  link_state_t      state_q, state_d;
  logic [DW-1:0]    delay_q, fill_cnt_q, delay_clamped;
  logic             lane_rev_q, line_flush;
  logic [LANES-1:0] txp_map, txn_map, tap_p, tap_n, err_mask;

  assign delay_clamped = (delay_cfg > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay_cfg;
  assign line_flush    = !sys_rst_n || (state_q == DOWN);
  assign link_up       = (state_q == UP);
  assign link_state    = state_q;

  // Next-state logic; dropping link_en overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DOWN:    if (link_en) state_d = FILL;
      FILL:    if (!delay_cfg_we && (fill_cnt_q == delay_q)) state_d = UP;
      UP:      if (delay_cfg_we) state_d = FILL;
      default: state_d = DOWN;
    endcase
    if (!link_en) state_d = DOWN;
  end

  // FSM state register.
  always_ff @(posedge clk_200) begin
    if (!sys_rst_n) state_q <= DOWN;
    else            state_q <= state_d;
  end

  // Delay register, lane-reversal latch and fill counter.
  always_ff @(posedge clk_200) begin
    if (!sys_rst_n) begin
      delay_q    <= DW'(DEFAULT_DELAY);
      fill_cnt_q <= '0;
      lane_rev_q <= 1'b0;
    end else begin
      if (delay_cfg_we) delay_q <= delay_clamped;
      if ((state_q == DOWN) && (state_d == FILL)) lane_rev_q <= lane_rev;
      if ((state_q == FILL) && (state_d == FILL) && !delay_cfg_we)
        fill_cnt_q <= fill_cnt_q + DW'(1);
      else
        fill_cnt_q <= '0;
    end
  end

  // Lane reversal is applied on entry so both delay lines carry mapped lanes.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      txp_map[i] = lane_rev_q ? lanes.pci_exp_txp[LANES-1-i] : lanes.pci_exp_txp[i];
      txn_map[i] = lane_rev_q ? lanes.pci_exp_txn[LANES-1-i] : lanes.pci_exp_txn[i];
    end
  end

  pcie_loop_delay_line #(.WIDTH(LANES), .MAX_DELAY(MAX_DELAY), .IDLE(IDLE_P)) u_line_p (
    .clk_200 (clk_200),
    .flush   (line_flush),
    .delay   (delay_q),
    .din     (txp_map),
    .dout    (tap_p)
  );

  pcie_loop_delay_line #(.WIDTH(LANES), .MAX_DELAY(MAX_DELAY), .IDLE(IDLE_N)) u_line_n (
    .clk_200 (clk_200),
    .flush   (line_flush),
    .delay   (delay_q),
    .din     (txn_map),
    .dout    (tap_n)
  );

`ifdef PCIE_LOOP_ERR_INJECT_EN
  logic [15:0] period_q;
  logic [31:0] err_count_q;
  logic        inject_hit, inject_lane_ok;

  assign inject_hit     = (state_d == UP) && (err_every != 16'd0) &&
                          (period_q == err_every - 16'd1);
  assign inject_lane_ok = (err_lane < EW'(LANES));
  assign err_count      = err_count_q;

  // One-hot flip mask for the selected lane on an injection cycle.
  always_comb begin
    err_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (inject_hit && inject_lane_ok && (err_lane == EW'(i))) err_mask[i] = 1'b1;
    end
  end

  // Period counter runs over UP output cycles; saturating error tally.
  always_ff @(posedge clk_200) begin
    if (!sys_rst_n) begin
      period_q    <= '0;
      err_count_q <= '0;
    end else if (state_d == UP) begin
      period_q <= inject_hit ? 16'd0 : period_q + 16'd1;
      if (inject_hit && inject_lane_ok && (err_count_q != '1))
        err_count_q <= err_count_q + 32'd1;
    end else begin
      period_q <= '0;
    end
  end
`else
  logic unused_err_inputs;

  assign unused_err_inputs = ^{err_every, err_lane};
  assign err_mask          = '0;
  assign err_count         = '0;
`endif

  // Registered receive pairs: delayed data while UP, idle otherwise.
  always_ff @(posedge clk_200) begin
    if (!sys_rst_n || (state_d != UP)) begin
      lanes.pci_exp_rxp <= {LANES{IDLE_P}};
      lanes.pci_exp_rxn <= {LANES{IDLE_N}};
    end else begin
      lanes.pci_exp_rxp <= tap_p ^ err_mask;
      lanes.pci_exp_rxn <= tap_n ^ err_mask;
    end
  end

endmodule

// File: tb/tb_pcie_lane_loopback.sv
// Self-checking bench for pcie_lane_loopback (LANES=4, MAX_DELAY=32, DEFAULT_DELAY=4).
// Expected behaviour comes from a cycle-history reference model plus
// hand-derived constants for the table and corner-case sequences.
module tb_pcie_lane_loopback;

  localparam int LANES         = 4;
  localparam int MAX_DELAY     = 32;
  localparam int DEFAULT_DELAY = 4;
  localparam int DW            = $clog2(MAX_DELAY + 1);
  localparam int EW            = $clog2(LANES) + 1;
  localparam int NEVER         = 32'h7fff_ffff;
`ifdef PCIE_LOOP_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic          clk_200 = 1'b0;
  logic          sys_rst_n, link_en, lane_rev, delay_cfg_we;
  logic [DW-1:0] delay_cfg;
  logic [15:0]   err_every;
  logic [EW-1:0] err_lane;
  logic [3:0]    tx_p, tx_n;
  logic          link_up;
  logic [1:0]    link_state;
  logic [31:0]   err_count;

  int total = 0;
  int bad   = 0;

  pcie_lane_loopback_if #(.LANES(LANES)) lanes_if ();

  assign lanes_if.pci_exp_txp = tx_p;
  assign lanes_if.pci_exp_txn = tx_n;

  pcie_lane_loopback #(
    .LANES(LANES), .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(DEFAULT_DELAY)
  ) dut (
    .clk_200      (clk_200),
    .sys_rst_n    (sys_rst_n),
    .link_en      (link_en),
    .lane_rev     (lane_rev),
    .delay_cfg    (delay_cfg),
    .delay_cfg_we (delay_cfg_we),
    .lanes        (lanes_if),
    .link_up      (link_up),
    .link_state   (link_state),
    .err_every    (err_every),
    .err_lane     (err_lane),
    .err_count    (err_count)
  );

  always #5 clk_200 = ~clk_200;

  // Reference model: link is up from cycle m_up_from onward; rx replays tx history.
  int          cyc = 0;
  int          m_up_from = NEVER;
  int          m_delay = DEFAULT_DELAY;
  bit          m_rev = 1'b0;
  int unsigned m_errs = 0;
  logic [3:0]  hist_p [64];
  logic [3:0]  hist_n [64];
  logic [3:0]  e_rxp = '0, e_rxn = '0;
  logic [1:0]  e_state = 2'd0;
  logic        e_up = 1'b0;

  function automatic logic [3:0] mapLanes(logic [3:0] v, bit rev);
    logic [3:0] r;
    r = rev ? {<<{v}} : v;
    return r;
  endfunction

  task automatic modelStep();
    int nd, k, ev;
    hist_p[cyc % 64] = tx_p;
    hist_n[cyc % 64] = tx_n;
    if (!sys_rst_n) begin
      m_up_from = NEVER;
      m_delay   = DEFAULT_DELAY;
      m_errs    = 0;
      m_rev     = 1'b0;
    end else begin
      nd = delay_cfg_we ? ((int'(delay_cfg) > MAX_DELAY) ? MAX_DELAY : int'(delay_cfg)) : m_delay;
      if (!link_en) m_up_from = NEVER;
      else if (m_up_from == NEVER) begin
        m_up_from = cyc + 2 + nd;
        m_rev     = lane_rev;
      end else if (delay_cfg_we) m_up_from = cyc + 2 + nd;
      m_delay = nd;
    end
    e_up  = sys_rst_n && (cyc + 1 >= m_up_from);
    e_rxp = '0;
    e_rxn = '0;
    if (e_up) begin
      e_rxp = mapLanes(hist_p[(cyc - m_delay) % 64], m_rev);
      e_rxn = mapLanes(hist_n[(cyc - m_delay) % 64], m_rev);
      k  = cyc + 1 - m_up_from;
      ev = int'(err_every);
      if (INJ && ev != 0 && (k % ev) == ev - 1 && int'(err_lane) < LANES) begin
        e_rxp[err_lane] = ~e_rxp[err_lane];
        e_rxn[err_lane] = ~e_rxn[err_lane];
        m_errs++;
      end
    end
    e_state = (!sys_rst_n || m_up_from == NEVER) ? 2'd0 : (e_up ? 2'd2 : 2'd1);
    cyc++;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock with the currently driven inputs; sample #1 after the edge.
  task automatic applyStimulus();
    @(posedge clk_200);
    #1;
    modelStep();
  endtask

  task automatic checkOutput();
    checkValue("rxp", {28'd0, lanes_if.pci_exp_rxp}, {28'd0, e_rxp});
    checkValue("rxn", {28'd0, lanes_if.pci_exp_rxn}, {28'd0, e_rxn});
    checkValue("link_state", {30'd0, link_state}, {30'd0, e_state});
    checkValue("link_up", {31'd0, link_up}, {31'd0, e_up});
    checkValue("err_count", err_count, m_errs);
  endtask

  // Caller sets the initiating inputs; counts non-up cycles until link_up rises.
  task automatic measureFill(input int budget, output int idle);
    bit seen;
    seen = 1'b0;
    idle = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      applyStimulus();
      checkOutput();
      delay_cfg_we = 1'b0;
      if (link_up === 1'b1) seen = 1'b1;
      else idle++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL fill_timeout: link_up still low after %0d cycles", budget);
    end
  endtask

  // Sends one marker word through an otherwise zero stream and times its return.
  task automatic measureLatency(input int budget, output int lat);
    tx_p = 4'h0;
    tx_n = 4'h0;
    repeat (40) begin
      applyStimulus();
      checkOutput();
    end
    tx_p = 4'hA;
    tx_n = 4'h5;
    lat = -1;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      applyStimulus();
      checkOutput();
      tx_p = 4'h0;
      tx_n = 4'h0;
      if (lanes_if.pci_exp_rxp == 4'hA && lanes_if.pci_exp_rxn == 4'h5) lat = i;
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] txp;
    logic [3:0] txn;
    logic [1:0] x_state;
    logic       x_up;
    logic [3:0] x_rxp;
    logic [3:0] x_rxn;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int idle, lat;

    sys_rst_n = 1'b0; link_en = 1'b0; lane_rev = 1'b0;
    delay_cfg = '0; delay_cfg_we = 1'b0;
    err_every = 16'd0; err_lane = '0;
    tx_p = 4'h0; tx_n = 4'h0;

    // Reset then link-up at default delay 4: rx row k returns tx of row k-4.
    vecs[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 1'b1, 4'h1, 4'h7, 2'd1, 1'b0, 4'h0, 4'h0};
    vecs[2]  = '{1'b1, 1'b1, 4'h2, 4'hE, 2'd1, 1'b0, 4'h0, 4'h0};
    vecs[3]  = '{1'b1, 1'b1, 4'h4, 4'hD, 2'd1, 1'b0, 4'h0, 4'h0};
    vecs[4]  = '{1'b1, 1'b1, 4'h8, 4'hB, 2'd1, 1'b0, 4'h0, 4'h0};
    vecs[5]  = '{1'b1, 1'b1, 4'h3, 4'h1, 2'd1, 1'b0, 4'h0, 4'h0};
    vecs[6]  = '{1'b1, 1'b1, 4'h6, 4'h2, 2'd2, 1'b1, 4'h2, 4'hE};
    vecs[7]  = '{1'b1, 1'b1, 4'hC, 4'h4, 2'd2, 1'b1, 4'h4, 4'hD};
    vecs[8]  = '{1'b1, 1'b1, 4'h9, 4'h8, 2'd2, 1'b1, 4'h8, 4'hB};
    vecs[9]  = '{1'b1, 1'b1, 4'h5, 4'h0, 2'd2, 1'b1, 4'h3, 4'h1};
    vecs[10] = '{1'b1, 1'b1, 4'hA, 4'hF, 2'd2, 1'b1, 4'h6, 4'h2};
    vecs[11] = '{1'b1, 1'b1, 4'hF, 4'h3, 2'd2, 1'b1, 4'hC, 4'h4};
    vecs[12] = '{1'b1, 1'b1, 4'h0, 4'hC, 2'd2, 1'b1, 4'h9, 4'h8};

    $display("[TB] table: reset and default-delay link-up");
    for (int i = 0; i < 13; i++) begin
      sys_rst_n = vecs[i].rst_n;
      link_en   = vecs[i].en;
      tx_p      = vecs[i].txp;
      tx_n      = vecs[i].txn;
      applyStimulus();
      checkOutput();
      checkValue("tbl_state", {30'd0, link_state}, {30'd0, vecs[i].x_state});
      checkValue("tbl_link_up", {31'd0, link_up}, {31'd0, vecs[i].x_up});
      checkValue("tbl_rxp", {28'd0, lanes_if.pci_exp_rxp}, {28'd0, vecs[i].x_rxp});
      checkValue("tbl_rxn", {28'd0, lanes_if.pci_exp_rxn}, {28'd0, vecs[i].x_rxn});
    end

    $display("[TB] delay rewrite while up");
    delay_cfg = 6'd10; delay_cfg_we = 1'b1;
    measureFill(60, idle);
    checkValue("fill_len_d10", idle, 11);
    measureLatency(60, lat);
    checkValue("latency_d10", lat, 11);
    delay_cfg = 6'd63; delay_cfg_we = 1'b1;
    measureFill(80, idle);
    checkValue("fill_len_clamped", idle, 33);
    measureLatency(60, lat);
    checkValue("latency_clamped", lat, 33);

    $display("[TB] lane reversal");
    link_en = 1'b0; delay_cfg = 6'd2; delay_cfg_we = 1'b1;
    applyStimulus(); checkOutput();
    delay_cfg_we = 1'b0;
    link_en = 1'b1; lane_rev = 1'b1; tx_p = 4'b0001; tx_n = 4'b0010;
    measureFill(20, idle);
    checkValue("fill_len_d2", idle, 3);
    checkValue("rev_rxp", {28'd0, lanes_if.pci_exp_rxp}, 32'b1000);
    checkValue("rev_rxn", {28'd0, lanes_if.pci_exp_rxn}, 32'b0100);
    lane_rev = 1'b0;
    repeat (4) begin applyStimulus(); checkOutput(); end
    checkValue("rev_hold_rxp", {28'd0, lanes_if.pci_exp_rxp}, 32'b1000);

    $display("[TB] link down together with delay write");
    link_en = 1'b0; delay_cfg = 6'd7; delay_cfg_we = 1'b1; tx_p = 4'h6; tx_n = 4'h9;
    applyStimulus(); checkOutput();
    delay_cfg_we = 1'b0;
    checkValue("down_state", {30'd0, link_state}, 32'd0);
    checkValue("down_rxp", {28'd0, lanes_if.pci_exp_rxp}, 32'd0);
    checkValue("down_rxn", {28'd0, lanes_if.pci_exp_rxn}, 32'd0);
    link_en = 1'b1;
    measureFill(30, idle);
    checkValue("fill_len_d7", idle, 8);

    $display("[TB] reset pulse while up");
    repeat (3) begin
      tx_p = 4'($urandom); tx_n = 4'($urandom);
      applyStimulus(); checkOutput();
    end
    sys_rst_n = 1'b0;
    applyStimulus(); checkOutput();
    checkValue("rst_state", {30'd0, link_state}, 32'd0);
    checkValue("rst_link_up", {31'd0, link_up}, 32'd0);
    checkValue("rst_rxp", {28'd0, lanes_if.pci_exp_rxp}, 32'd0);
    checkValue("rst_err_count", err_count, 32'd0);
    sys_rst_n = 1'b1;
    measureFill(30, idle);
    checkValue("fill_len_default", idle, DEFAULT_DELAY + 1);

    $display("[TB] periodic error injection");
    link_en = 1'b0;
    applyStimulus(); checkOutput();
    err_every = 16'd8; err_lane = 3'd2; tx_p = 4'h0; tx_n = 4'h0; link_en = 1'b1;
    measureFill(30, idle);
    for (int k = 1; k < 32; k++) begin
      applyStimulus(); checkOutput();
      checkValue("inj_rxp", {28'd0, lanes_if.pci_exp_rxp},
                 (INJ && (k % 8) == 7) ? 32'b0100 : 32'd0);
    end
    checkValue("inj_count_32", err_count, INJ ? 32'd4 : 32'd0);
    err_lane = 3'd7;
    repeat (16) begin applyStimulus(); checkOutput(); end
    checkValue("inj_count_bad_lane", err_count, INJ ? 32'd4 : 32'd0);

    $display("[TB] randomized traffic against reference model");
    for (int seg = 0; seg < 15; seg++) begin
      link_en = 1'b0; delay_cfg_we = 1'b0; sys_rst_n = 1'b1;
      applyStimulus(); checkOutput();
      err_every = 16'($urandom_range(0, 10));
      err_lane  = 3'($urandom_range(0, 7));
      for (int c = 0; c < 100; c++) begin
        sys_rst_n    = ($urandom_range(0, 199) != 0);
        link_en      = ($urandom_range(0, 49) != 0);
        lane_rev     = 1'($urandom);
        delay_cfg_we = ($urandom_range(0, 29) == 0);
        delay_cfg    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 63))
                                                   : 6'($urandom_range(0, 8));
        tx_p = 4'($urandom);
        tx_n = 4'($urandom);
        if ($urandom_range(0, 15) == 0) err_lane = 3'($urandom_range(0, 7));
        applyStimulus();
        checkOutput();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
